// File: rtl/miner_nonce_sched_pkg.sv
// Shared widths, FSM encoding and helpers for the nonce scheduler.
// Optional MINER_HASH_CNT_EN adds a digest counter in the top.
package miner_pkg;

  localparam int NONCE_W = 32;
  localparam int MSG_S   = 512;
  localparam int H_SIZE  = 256;

  typedef logic [NONCE_W-1:0] nonce_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/miner_nonce_sched_if.sv
// Block issue / digest return link between scheduler and sha_block.
// Master side issues blocks, slave side returns digests.
interface miner_nonce_sched_if;
  import miner_pkg::*;

  logic              sha_en;
  logic [MSG_S-1:0]  sha_M;
  logic [H_SIZE-1:0] sha_H;
  logic              sha_en_next;

  modport master (
    output sha_en,
    output sha_M,
    input  sha_H,
    input  sha_en_next
  );

  modport slave (
    input  sha_en,
    input  sha_M,
    output sha_H,
    output sha_en_next
  );

endinterface

// File: rtl/miner_nonce_sched_fifo.sv
// In-flight nonce order FIFO; same-cycle push and pop allowed.
// DEPTH must be a power of two.
module nonce_fifo
  import miner_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   push,
  input  logic   pop,
  input  nonce_t din,
  output logic   full,
  output logic   empty,
  output nonce_t head
);

  localparam int AW = ptr_w(DEPTH);
  localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];

  nonce_t        mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == CNT_FULL);
  assign empty   = (cnt == '0);
  assign head    = mem[rp];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      if (do_push && !do_pop) cnt <= cnt + 1'b1;
      else if (!do_push && do_pop) cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/miner_nonce_sched.sv
// Nonce scheduler: issues nonce blocks to sha_block, reports first hit.
// Define MINER_HASH_CNT_EN to add the hash_cnt digest counter output.
module miner_nonce_sched
  import miner_pkg::*;
#(
  parameter int NONCE_LSB      = 384,
  parameter int MAX_INFLIGHT   = 16,
  parameter int ISSUE_INTERVAL = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [MSG_S-1:0]    msg_tmpl,
  input  nonce_t              nonce_first,
  input  nonce_t              nonce_last,
  input  logic [H_SIZE-1:0]   target,
  miner_nonce_sched_if.master sha,
  output logic                busy,
  output logic                done,
  output logic                found,
  output nonce_t              nonce_found,
  output logic                err
`ifdef MINER_HASH_CNT_EN
  ,
  output logic [47:0]         hash_cnt
`endif
);

  localparam int GW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam logic [GW-1:0] GAP_RLD = GW'(ISSUE_INTERVAL - 1);

  logic [1:0]        state;
  logic [MSG_S-1:0]  msg_r;
  logic [MSG_S-1:0]  issue_m;
  logic [H_SIZE-1:0] tgt_r;
  nonce_t            cur;
  nonce_t            last_r;
  nonce_t            head;
  logic [GW-1:0]     gap;
  logic              full;
  logic              empty;
  logic              stop;
  logic              issue;
  logic              pop;

  // A recorded hit only stops issue from the cycle after it registers.
  assign stop  = abort | found;
  assign issue = (state == ST_ISSUE) & ~full & (gap == '0) & ~stop;
  assign pop   = sha.sha_en_next & ~empty;
  assign busy  = (state == ST_ISSUE) | (state == ST_DRAIN);
  assign done  = (state == ST_DONE);

  always_comb begin
    issue_m = msg_r;
    issue_m[NONCE_LSB +: NONCE_W] = cur;
  end

  nonce_fifo #(
    .DEPTH (MAX_INFLIGHT)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (issue),
    .pop   (pop),
    .din   (cur),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      msg_r       <= '0;
      tgt_r       <= '0;
      cur         <= '0;
      last_r      <= '0;
      gap         <= '0;
      found       <= 1'b0;
      nonce_found <= '0;
      err         <= 1'b0;
      sha.sha_en  <= 1'b0;
      sha.sha_M   <= '0;
    end else begin
      sha.sha_en <= issue;
      if (issue) begin
        sha.sha_M <= issue_m;
        cur       <= cur + 1'b1;
        gap       <= GAP_RLD;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      unique case (1'b1)
        (state == ST_IDLE): begin
          if (start) begin
            state       <= ST_ISSUE;
            msg_r       <= msg_tmpl;
            tgt_r       <= target;
            cur         <= nonce_first;
            last_r      <= nonce_last;
            gap         <= '0;
            found       <= 1'b0;
            nonce_found <= '0;
          end
        end
        (state == ST_ISSUE): begin
          if (stop) state <= ST_DRAIN;
          else if (issue && cur == last_r) state <= ST_DRAIN;
        end
        (state == ST_DRAIN): begin
          if (empty) state <= ST_DONE;
        end
        (state == ST_DONE): begin
          state <= ST_IDLE;
        end
      endcase
      if (pop && sha.sha_H <= tgt_r && !found) begin
        found       <= 1'b1;
        nonce_found <= head;
      end
      if (sha.sha_en_next && empty) err <= 1'b1;
    end
  end

`ifdef MINER_HASH_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) hash_cnt <= '0;
    else if (state == ST_IDLE && start) hash_cnt <= '0;
    else if (sha.sha_en_next && hash_cnt != '1) hash_cnt <= hash_cnt + 1'b1;
  end
`endif

endmodule
